ram_93422_ctl: RTL and testbench

- Sequencer and arbiter for one 93422 256x4 static RAM.
- Shares the RAM between a CPU port and a video scan port. The video port has fixed priority, and a starvation guard protects the CPU.
- Drives the RAM's asynchronous, level-sensitive strobes (`cs1_n`, `w_n`) with a setup/strobe discipline, so the address is always stable while write is low.
- Optional post-reset clear walks all 256 locations.
- Sits between the CPU bus decode, the video line logic and the RAM pins.

---
 rtl/ram_93422_pkg.sv | 35 +++
 rtl/ram_93422_prio.sv | 63 ++++++
 rtl/ram_93422_ctl.sv | 245 ++++++++++++++++++++++++
 tb/tb_ram_93422_ctl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_93422_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ram_93422_pkg
//  Purpose  : Shared types and constants for the 93422 RAM sequencer/arbiter.
//             Holds the sequencer state enum, the grant-owner enum, default
//             address/data widths and a small state classification helper.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_93422_pkg;

    localparam int c_def_aw = 8;
    localparam int c_def_dw = 4;

    typedef enum logic [2:0] {
        CLR_SETUP  = 3'd0,
        CLR_STROBE = 3'd1,
        IDLE       = 3'd2,
        SETUP      = 3'd3,
        STROBE     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_VID  = 2'd2
    } gnt_owner_e;

    // Every state other than IDLE is part of a clear or an access.
    function automatic logic state_is_busy(input state_e s);
        return (s != IDLE);
    endfunction

endpackage : ram_93422_pkg
`default_nettype wire

// File: rtl/ram_93422_prio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ram_93422_prio
//  Purpose  : Fixed-priority grant logic (video first) with a starvation
//             guard for the CPU port.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             cpu_req, vid_req    - current-cycle requests
//             gnt_strobe          - high when the sequencer can grant (IDLE)
//             gnt_owner           - combinational winner for this cycle
//  Notes    : The starvation counter counts video grants made while the CPU
//             is waiting; at STARVE_MAX the CPU takes the next grant.
//             STARVE_MAX must be at least 1.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_93422_prio
    import ram_93422_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       vid_req,
    input  logic       gnt_strobe,
    output gnt_owner_e gnt_owner
);

    localparam int              c_cw         = $clog2(STARVE_MAX + 1);
    localparam logic [c_cw-1:0] c_starve_max = c_cw'(STARVE_MAX);

    logic [c_cw-1:0] r_starve_cnt;
    logic            w_cpu_starved;

    assign w_cpu_starved = cpu_req && (r_starve_cnt == c_starve_max);

    always_comb begin
        gnt_owner = GNT_NONE;
        if (vid_req && !w_cpu_starved) begin
            gnt_owner = GNT_VID;
        end else if (cpu_req) begin
            gnt_owner = GNT_CPU;
        end
    end

    // Only a video grant against a waiting CPU advances the counter; any
    // other grant means the CPU is not being held off, so start over.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (gnt_strobe && (gnt_owner != GNT_NONE)) begin
            if ((gnt_owner == GNT_VID) && cpu_req) begin
                if (r_starve_cnt != c_starve_max) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

endmodule : ram_93422_prio
`default_nettype wire

// File: rtl/ram_93422_ctl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ram_93422_ctl
//  Purpose  : Sequencer and arbiter for one 93422 256x4 static RAM shared by
//             a CPU port and a video scan port. Every access is three cycles:
//             grant (IDLE) -> SETUP (select, address stable) -> STROBE (write
//             low or read sample) -> back in IDLE with a one-cycle ack.
//  Ports    : clk, reset                          - clock, sync active-high
//             cpu_req/we/addr/wdata, cpu_ack/rdata - CPU port
//             vid_req/addr, vid_ack/rdata          - video read port
//             ram_a, ram_i, ram_d                  - RAM address/data pins
//             ram_cs1_n, ram_w_n, ram_oe_n         - RAM strobes, active low
//             busy                                 - clear or access underway
//  Config   : RAM93422_CLEAR_EN - when defined, reset runs a 512-cycle clear
//             writing CLEAR_VAL to all 256 locations before serving requests.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_93422_ctl
    import ram_93422_pkg::*;
#(
    parameter int            AW         = c_def_aw,
    parameter int            DW         = c_def_dw,
    parameter int            STARVE_MAX = 4,
    parameter logic [DW-1:0] CLEAR_VAL  = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_i,
    input  logic [DW-1:0] ram_d,
    output logic          ram_cs1_n,
    output logic          ram_w_n,
    output logic          ram_oe_n,
    output logic          busy
);

`ifdef RAM93422_CLEAR_EN
    localparam state_e c_rst_state = CLR_SETUP;
    localparam logic   c_rst_busy  = 1'b1;
`else
    localparam state_e c_rst_state = IDLE;
    localparam logic   c_rst_busy  = 1'b0;
`endif

    // Registered state and outputs
    state_e        r_state;
    logic [AW-1:0] r_ram_a;
    logic [DW-1:0] r_ram_i;
    logic          r_cs1_n;
    logic          r_w_n;
    logic          r_oe_n;
    logic          r_cpu_ack;
    logic          r_vid_ack;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_vid_rdata;
    logic          r_busy;
    logic [AW-1:0] r_clr_cnt;
    gnt_owner_e    r_owner;
    logic          r_we;

    // Next-state values
    state_e        w_state_nxt;
    logic [AW-1:0] w_ram_a_nxt;
    logic [DW-1:0] w_ram_i_nxt;
    logic          w_cs1_n_nxt;
    logic          w_w_n_nxt;
    logic          w_oe_n_nxt;
    logic          w_cpu_ack_nxt;
    logic          w_vid_ack_nxt;
    logic [DW-1:0] w_cpu_rdata_nxt;
    logic [DW-1:0] w_vid_rdata_nxt;
    logic [AW-1:0] w_clr_cnt_nxt;
    gnt_owner_e    w_owner_nxt;
    logic          w_we_nxt;

    gnt_owner_e    w_gnt_owner;
    logic          w_gnt_strobe;

    assign w_gnt_strobe = (r_state == IDLE);

    ram_93422_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .vid_req    (vid_req),
        .gnt_strobe (w_gnt_strobe),
        .gnt_owner  (w_gnt_owner)
    );

    // Output registers are loaded on the edge that enters a state, so the
    // pin levels seen during a cycle are those belonging to that state.
    always_comb begin
        w_state_nxt     = r_state;
        w_ram_a_nxt     = r_ram_a;
        w_ram_i_nxt     = r_ram_i;
        w_cs1_n_nxt     = r_cs1_n;
        w_w_n_nxt       = r_w_n;
        w_oe_n_nxt      = r_oe_n;
        w_cpu_ack_nxt   = 1'b0;
        w_vid_ack_nxt   = 1'b0;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_vid_rdata_nxt = r_vid_rdata;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_owner_nxt     = r_owner;
        w_we_nxt        = r_we;

        case (r_state)
            CLR_SETUP: begin
                // Address is already on the pins; drop write for one cycle.
                // ram_i is re-driven here because the first location after
                // reset enters with ram_i at its reset value; the RAM latches
                // data on the rising edge of write, so this is in time.
                w_state_nxt = CLR_STROBE;
                w_ram_i_nxt = CLEAR_VAL;
                w_cs1_n_nxt = 1'b0;
                w_w_n_nxt   = 1'b0;
            end

            CLR_STROBE: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                w_w_n_nxt     = 1'b1;
                if (r_clr_cnt == {AW{1'b1}}) begin
                    w_state_nxt = IDLE;
                    w_cs1_n_nxt = 1'b1;
                end else begin
                    w_state_nxt = CLR_SETUP;
                    w_ram_a_nxt = r_clr_cnt + 1'b1;
                    w_ram_i_nxt = CLEAR_VAL;
                    w_cs1_n_nxt = 1'b0;
                end
            end

            IDLE: begin
                if (w_gnt_owner == GNT_CPU) begin
                    w_state_nxt = SETUP;
                    w_owner_nxt = GNT_CPU;
                    w_we_nxt    = cpu_we;
                    w_ram_a_nxt = cpu_addr;
                    w_ram_i_nxt = cpu_wdata;
                    w_cs1_n_nxt = 1'b0;
                    w_oe_n_nxt  = cpu_we;
                end else if (w_gnt_owner == GNT_VID) begin
                    w_state_nxt = SETUP;
                    w_owner_nxt = GNT_VID;
                    w_we_nxt    = 1'b0;
                    w_ram_a_nxt = vid_addr;
                    w_cs1_n_nxt = 1'b0;
                    w_oe_n_nxt  = 1'b0;
                end
            end

            SETUP: begin
                w_state_nxt = STROBE;
                if (r_we) begin
                    w_w_n_nxt = 1'b0;
                end
            end

            STROBE: begin
                // Release the strobes with the address still held; the ack
                // cycle is also IDLE, so a new grant may be taken in it.
                w_state_nxt = IDLE;
                w_cs1_n_nxt = 1'b1;
                w_w_n_nxt   = 1'b1;
                w_oe_n_nxt  = 1'b1;
                if (r_owner == GNT_CPU) begin
                    w_cpu_ack_nxt = 1'b1;
                    if (!r_we) begin
                        w_cpu_rdata_nxt = ram_d;
                    end
                end else begin
                    w_vid_ack_nxt   = 1'b1;
                    w_vid_rdata_nxt = ram_d;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cs1_n_nxt = 1'b1;
                w_w_n_nxt   = 1'b1;
                w_oe_n_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_rst_state;
            r_ram_a     <= '0;
            r_ram_i     <= '0;
            r_cs1_n     <= 1'b1;
            r_w_n       <= 1'b1;
            r_oe_n      <= 1'b1;
            r_cpu_ack   <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_busy      <= c_rst_busy;
            r_clr_cnt   <= '0;
            r_owner     <= GNT_NONE;
            r_we        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ram_a     <= w_ram_a_nxt;
            r_ram_i     <= w_ram_i_nxt;
            r_cs1_n     <= w_cs1_n_nxt;
            r_w_n       <= w_w_n_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_vid_ack   <= w_vid_ack_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_vid_rdata <= w_vid_rdata_nxt;
            r_busy      <= state_is_busy(w_state_nxt);
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_owner     <= w_owner_nxt;
            r_we        <= w_we_nxt;
        end
    end

    assign ram_a     = r_ram_a;
    assign ram_i     = r_ram_i;
    assign ram_cs1_n = r_cs1_n;
    assign ram_w_n   = r_w_n;
    assign ram_oe_n  = r_oe_n;
    assign cpu_ack   = r_cpu_ack;
    assign vid_ack   = r_vid_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign vid_rdata = r_vid_rdata;
    assign busy      = r_busy;

endmodule : ram_93422_ctl
`default_nettype wire

// File: tb/tb_ram_93422_ctl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ram_93422_ctl
//  Purpose  : Self-checking bench for ram_93422_ctl with a behavioural 93422
//             model and a reference memory image. Works with or without
//             RAM93422_CLEAR_EN defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_93422_ctl;

    localparam int         STARVE_MAX = 4;
    localparam logic [3:0] CLEAR_VAL  = 4'h0;
`ifdef RAM93422_CLEAR_EN
    localparam int         CLR_CYCLES = 512;
    localparam logic       RST_BUSY   = 1'b1;
`else
    localparam int         CLR_CYCLES = 0;
    localparam logic       RST_BUSY   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_ack;
    logic [7:0] cpu_addr;
    logic [3:0] cpu_wdata, cpu_rdata;
    logic       vid_req, vid_ack;
    logic [7:0] vid_addr;
    logic [3:0] vid_rdata;
    logic [7:0] ram_a;
    logic [3:0] ram_i, ram_d;
    logic       ram_cs1_n, ram_w_n, ram_oe_n, busy;

    always #5 clk = ~clk;

    ram_93422_ctl #(
        .AW(8), .DW(4), .STARVE_MAX(STARVE_MAX), .CLEAR_VAL(CLEAR_VAL)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdata(vid_rdata),
        .ram_a(ram_a), .ram_i(ram_i), .ram_d(ram_d),
        .ram_cs1_n(ram_cs1_n), .ram_w_n(ram_w_n), .ram_oe_n(ram_oe_n),
        .busy(busy)
    );

    // ---------------- 93422 model + reference image ----------------
    logic [3:0] mem     [0:255];
    logic [3:0] ref_mem [0:255];
    logic       load_en = 1'b0;

    // Deselected/undriven reads return the complement so a missing strobe
    // shows up as wrong data.
    assign ram_d = (!ram_cs1_n && !ram_oe_n) ? mem[ram_a] : ~mem[ram_a];

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (!ram_cs1_n && !ram_w_n) begin
            mem[ram_a] <= ram_i;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- pin protocol monitor ----------------
    bit         mon_en   = 1'b0;
    int         wlow     = 0;
    logic [7:0] prev_a   = '0;
    logic       prev_wn  = 1'b1;
    logic       prev_rst = 1'b1;

    always @(negedge clk) begin
        if (mon_en && !prev_rst) begin
            if (!ram_w_n) begin
                wlow <= wlow + 1;
                check_val("wr_cs_low", ram_cs1_n, 1'b0);
                check_val("wr_addr_setup", ram_a, prev_a);
            end
            if (!prev_wn && !busy) begin
                check_val("wr_addr_hold", ram_a, prev_a);
                check_val("wr_single_cycle", ram_w_n, 1'b1);
            end
            if (cpu_ack || vid_ack) check_val("ack_exclusive", cpu_ack & vid_ack, 1'b0);
        end
        prev_a   <= ram_a;
        prev_wn  <= ram_w_n;
        prev_rst <= reset;
    end

    // ---------------- helpers ----------------
    // Counts cycles with busy high after reset release; CPU acks must not
    // appear meanwhile. Refreshes the reference image when a clear ran.
    task automatic measure_clear();
        int bc;
        int acks;
        bc = 0;
        acks = 0;
        while (busy && bc < 600) begin
            @(posedge clk); #1;
            bc++;
            if (cpu_ack) acks++;
        end
        check_val("clear_busy_cycles", bc, CLR_CYCLES);
        check_val("clear_no_cpu_ack", acks, 0);
`ifdef RAM93422_CLEAR_EN
        check_val("clear_mem_00", mem[8'h00], CLEAR_VAL);
        check_val("clear_mem_7f", mem[8'h7F], CLEAR_VAL);
        check_val("clear_mem_ff", mem[8'hFF], CLEAR_VAL);
        for (int i = 0; i < 256; i++) ref_mem[i] = CLEAR_VAL;
`endif
    endtask

    // One CPU access started from IDLE; checks latency, pin phases and data.
    task automatic cpu_access(input logic we, input logic [7:0] addr, input logic [3:0] wd);
        int lat;
        int w0;
        lat = 0;
        w0  = wlow;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                check_val("acc_busy", busy, 1'b1);
                check_val("acc_cs_setup", ram_cs1_n, 1'b0);
                check_val("acc_oe_setup", ram_oe_n, we);
                check_val("acc_addr", ram_a, addr);
                if (we) check_val("acc_wdata", ram_i, wd);
            end
        end while (!cpu_ack && lat < 40);
        cpu_req = 1'b0;
        check_val("cpu_latency", lat, 3);
        check_val("cpu_wpulses", wlow - w0, we ? 1 : 0);
        check_val("ack_busy_low", busy, 1'b0);
        if (we) ref_mem[addr] = wd;
        else    check_val("cpu_rdata", cpu_rdata, ref_mem[addr]);
        @(posedge clk); #1;
        check_val("cpu_ack_pulse", cpu_ack, 1'b0);
        check_val("cpu_rdata_hold", cpu_rdata, we ? cpu_rdata : ref_mem[addr]);
    endtask

    // Both ports request continuously; expected winner from the rule
    // "video wins unless the CPU has waited through STARVE_MAX video grants".
    task automatic run_both(input int n);
        int got;
        int cyc;
        int last;
        int streak;
        logic exp_cpu;
        got = 0; cyc = 0; last = 0; streak = 0;
        cpu_we   = 1'b0;
        cpu_addr = 8'($urandom_range(0, 255));
        vid_addr = 8'($urandom_range(0, 255));
        cpu_req  = 1'b1;
        vid_req  = 1'b1;
        while (got < n && cyc < n * 3 + 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cpu_ack || vid_ack) begin
                exp_cpu = (streak == STARVE_MAX);
                check_val("both_order_cpu", cpu_ack, exp_cpu);
                check_val("both_order_vid", vid_ack, !exp_cpu);
                check_val("both_spacing", cyc - last, 3);
                streak = exp_cpu ? 0 : streak + 1;
                if (cpu_ack) begin
                    check_val("both_cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
                    cpu_addr = 8'($urandom_range(0, 255));
                end
                if (vid_ack) begin
                    check_val("both_vid_rdata", vid_rdata, ref_mem[vid_addr]);
                    vid_addr = 8'($urandom_range(0, 255));
                end
                got++;
                last = cyc;
            end
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        check_val("both_grant_count", got, n);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acks;
        int ack_at;
        int cyc;
        int last;
        logic [7:0] a;
        logic [3:0] d;

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 4'($urandom_range(0, 15));
        load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check_val("rst_cs1_n", ram_cs1_n, 1'b1);
        check_val("rst_w_n", ram_w_n, 1'b1);
        check_val("rst_oe_n", ram_oe_n, 1'b1);
        check_val("rst_ram_a", ram_a, 8'h00);
        check_val("rst_ram_i", ram_i, 4'h0);
        check_val("rst_cpu_ack", cpu_ack, 1'b0);
        check_val("rst_vid_ack", vid_ack, 1'b0);
        check_val("rst_cpu_rdata", cpu_rdata, 4'h0);
        check_val("rst_vid_rdata", vid_rdata, 4'h0);
        check_val("rst_busy", busy, RST_BUSY);

`ifdef RAM93422_CLEAR_EN
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h7F;
`endif
        reset  = 1'b0;
        mon_en = 1'b1;
        measure_clear();
`ifdef RAM93422_CLEAR_EN
        cyc = 0;
        while (!cpu_ack && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        cpu_req = 1'b0;
        check_val("clear_cpu_latency", cyc, 3);
        check_val("clear_cpu_rdata", cpu_rdata, CLEAR_VAL);
        @(posedge clk); #1;
`endif

        // Directed write then read of 0x3C
        cpu_access(1'b1, 8'h3C, 4'hA);
        cpu_access(1'b0, 8'h3C, 4'h0);
        check_val("rd_3c_value", cpu_rdata, 4'hA);

        // Random CPU traffic against the reference image
        for (int k = 0; k < 24; k++) begin
            cpu_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                       4'($urandom_range(0, 15)));
        end

        // One-cycle request pulse gives exactly one access
        a = 8'($urandom_range(0, 255));
        cpu_we = 1'b0; cpu_addr = a; cpu_req = 1'b1;
        acks = 0; ack_at = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            if (cpu_ack) begin
                acks++;
                ack_at = c;
                check_val("pulse_rdata", cpu_rdata, ref_mem[a]);
            end
        end
        check_val("pulse_ack_count", acks, 1);
        check_val("pulse_ack_cycle", ack_at, 3);

        // Contended requests: video x4, CPU, video x4, CPU
        run_both(10);

        // Back-to-back video sweep of the whole array, CPU idle
        vid_addr = 8'h00; vid_req = 1'b1;
        acks = 0; cyc = 0; last = 0;
        while (acks < 256 && cyc < 900) begin
            @(posedge clk); #1;
            cyc++;
            if (cpu_ack) check_val("sweep_no_cpu_ack", cpu_ack, 1'b0);
            if (vid_ack) begin
                check_val("sweep_rdata", vid_rdata, ref_mem[vid_addr]);
                check_val("sweep_spacing", cyc - last, 3);
                last = cyc;
                acks++;
                vid_addr = vid_addr + 8'd1;
            end
        end
        vid_req = 1'b0;
        check_val("sweep_ack_count", acks, 256);
        repeat (4) @(posedge clk);
        #1;

        // Starvation count must have stayed at zero through the sweep
        run_both(5);

        // Reset during STROBE of a CPU write
        a = 8'h55;
        d = ~ref_mem[a];
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rs_strobe_wlow", ram_w_n, 1'b0);
        reset = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check_val("rs_w_n_high", ram_w_n, 1'b1);
        check_val("rs_cs_high", ram_cs1_n, 1'b1);
        check_val("rs_no_ack", cpu_ack, 1'b0);
        check_val("rs_ram_a", ram_a, 8'h00);
        check_val("rs_busy", busy, RST_BUSY);
        ref_mem[a] = d;
        reset = 1'b0;
        measure_clear();
        cpu_access(1'b0, a, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "timeout");
    end

endmodule : tb_ram_93422_ctl
`default_nettype wire
